direction_cmd_uart_tx: RTL and testbench

// - Encoder/transmitter counterpart of the manual-mode command decoder: takes one-hot direction flags
//   (w,s,a,d,wa,wd,as,ds,stop) from the decision tree, encodes them to the 8-bit Arduino command byte, and sends it
//   as a UART frame (8N1) to the Arduino/motor link.
// - Sends on command change and on a periodic refresh, so a lost byte is recovered.

---
 rtl/dir_cmd_pkg.sv | 56 +++++
 rtl/direction_cmd_uart_tx_baud_tick.sv | 37 +++
 rtl/direction_cmd_uart_tx.sv | 175 +++++++++++++++++
 tb/tb_direction_cmd_uart_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dir_cmd_pkg.sv
// Shared definitions for the direction command link: Arduino command bytes, the TX state type and the flag encoder.
// DIR_TX_PARITY_EN adds the PARITY state for an 8E1 frame.
package dir_cmd_pkg;

  localparam logic [7:0] CMD_STOP  = 8'h00;
  localparam logic [7:0] CMD_FWD   = 8'h01;
  localparam logic [7:0] CMD_LEFT  = 8'h02;
  localparam logic [7:0] CMD_LF    = 8'h03;
  localparam logic [7:0] CMD_BACK  = 8'h04;
  localparam logic [7:0] CMD_LB    = 8'h06;
  localparam logic [7:0] CMD_RIGHT = 8'h08;
  localparam logic [7:0] CMD_RF    = 8'h09;
  localparam logic [7:0] CMD_RB    = 8'h0C;

`ifdef DIR_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd4
  } tx_state_t;
`endif

  // dirs is {w,a,s,d,wa,wd,as,ds}; anything other than a single request (or any stop) maps to STOP.
  function automatic logic [7:0] encode_dir(input logic [7:0] dirs, input logic stop);
    logic [7:0] code;
    code = CMD_STOP;
    if (!stop) begin
      case (dirs)
        8'b1000_0000: code = CMD_FWD;
        8'b0100_0000: code = CMD_LEFT;
        8'b0010_0000: code = CMD_BACK;
        8'b0001_0000: code = CMD_RIGHT;
        8'b0000_1000: code = CMD_LF;
        8'b0000_0100: code = CMD_RF;
        8'b0000_0010: code = CMD_LB;
        8'b0000_0001: code = CMD_RB;
        default:      code = CMD_STOP;
      endcase
    end
    return code;
  endfunction

  function automatic logic multi_dir(input logic [7:0] dirs);
    return !$onehot0(dirs);
  endfunction

endpackage

// File: rtl/direction_cmd_uart_tx_baud_tick.sv
// Bit-period timer for the direction command transmitter: one-clock bit_tick every CLKS_PER_BIT clocks while running,
// realigned to the frame by restart.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = RELOAD;
    end else if (run) begin
      cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_tick = run && (cnt_q == '0);

endmodule

// File: rtl/direction_cmd_uart_tx.sv
// Direction flags -> Arduino command byte -> UART frame, resent on change and on a periodic refresh.
// Define DIR_TX_PARITY_EN for an even-parity 8E1 frame; default is 8N1.
module direction_cmd_uart_tx
  import dir_cmd_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 115_200,
  parameter int REFRESH_CYCLES = 5_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       w,
  input  logic       s,
  input  logic       a,
  input  logic       d,
  input  logic       wa,
  input  logic       wd,
  input  logic       as,
  input  logic       ds,
  input  logic       stop,
  input  logic       tx_en,
  output logic       uart_tx,
  output logic       busy,
  output logic [7:0] sent_cmd,
  output logic       err_dir
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam logic [31:0] REFRESH_LAST = 32'(REFRESH_CYCLES - 1);

  logic [7:0] dirs;
  logic [7:0] cur_cmd_q, cur_cmd_d;
  logic       err_q, err_d;
  logic [7:0] sent_cmd_q, sent_cmd_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic [31:0] refresh_q, refresh_d;
  tx_state_t  state_q, state_d;

  logic bit_tick;
  logic refresh_expired;
  logic launch;
  logic frame_start;

  always_comb begin
    dirs      = {w, a, s, d, wa, wd, as, ds};
    cur_cmd_d = encode_dir(dirs, stop);
    err_d     = err_q | multi_dir(dirs);
  end

  assign refresh_expired = (REFRESH_CYCLES != 0) && (refresh_q == REFRESH_LAST);
  assign launch          = ((cur_cmd_q != sent_cmd_q) || refresh_expired) && tx_en;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (frame_start),
    .run     (busy_q),
    .bit_tick(bit_tick)
  );

  // The refresh counter saturates so an expired refresh stays pending while tx_en is low.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    sent_cmd_d  = sent_cmd_q;
    refresh_d   = refresh_q;
    frame_start = 1'b0;

    if (state_q == IDLE && REFRESH_CYCLES != 0 && !refresh_expired) begin
      refresh_d = refresh_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (launch) frame_start = 1'b1;
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          tx_d      = shift_q[0];
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef DIR_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = ^sent_cmd_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef DIR_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        // A still-differing command chains straight into the next start bit.
        if (bit_tick) begin
          if (launch) begin
            frame_start = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (frame_start) begin
      state_d    = START;
      shift_d    = cur_cmd_q;
      sent_cmd_d = cur_cmd_q;
      tx_d       = 1'b0;
      busy_d     = 1'b1;
      refresh_d  = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_cmd_q  <= CMD_STOP;
      err_q      <= 1'b0;
      sent_cmd_q <= 8'h00;
      shift_q    <= 8'h00;
      bit_cnt_q  <= 3'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      refresh_q  <= 32'd0;
      state_q    <= IDLE;
    end else begin
      cur_cmd_q  <= cur_cmd_d;
      err_q      <= err_d;
      sent_cmd_q <= sent_cmd_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      refresh_q  <= refresh_d;
      state_q    <= state_d;
    end
  end

  assign uart_tx  = tx_q;
  assign busy     = busy_q;
  assign sent_cmd = sent_cmd_q;
  assign err_dir  = err_q;

endmodule

// File: tb/tb_direction_cmd_uart_tx.sv
// Self-checking bench for direction_cmd_uart_tx: a serial monitor decodes frames and checks them against a queue of
// expected command bytes pushed by the stimulus. Honours DIR_TX_PARITY_EN.
module tb_direction_cmd_uart_tx;

`ifdef DIR_TX_PARITY_EN
  localparam int FRAME_CLKS = 110;
`else
  localparam int FRAME_CLKS = 100;
`endif
  localparam int REFRESH_PERIOD = 200 + FRAME_CLKS;

  // Flag order {w,s,a,d,wa,wd,as,ds,stop}
  localparam logic [8:0] F_W    = 9'b1_0000_0000;
  localparam logic [8:0] F_S    = 9'b0_1000_0000;
  localparam logic [8:0] F_A    = 9'b0_0100_0000;
  localparam logic [8:0] F_D    = 9'b0_0010_0000;
  localparam logic [8:0] F_WA   = 9'b0_0001_0000;
  localparam logic [8:0] F_WD   = 9'b0_0000_1000;
  localparam logic [8:0] F_AS   = 9'b0_0000_0100;
  localparam logic [8:0] F_DS   = 9'b0_0000_0010;
  localparam logic [8:0] F_STOP = 9'b0_0000_0001;

  localparam logic [8:0] SEQ_FLAGS [7] = '{F_A, F_D, F_WA, F_WD, F_AS, F_DS, F_STOP};
  localparam logic [7:0] SEQ_BYTES [7] = '{8'h02, 8'h08, 8'h03, 8'h09, 8'h06, 8'h0C, 8'h00};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       w, s, a, d, wa, wd, as, ds, stop;
  logic       tx_en;
  logic       uart_tx;
  logic       busy;
  logic [7:0] sent_cmd;
  logic       err_dir;

  int compareCount  = 0;
  int mismatchCount = 0;
  int cycle         = 0;
  bit monEnable     = 1'b1;
  logic [7:0] expQ[$];
  int startQ[$];

  direction_cmd_uart_tx #(
    .CLK_FREQ      (1000),
    .BAUD          (100),
    .REFRESH_CYCLES(200)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .w       (w),
    .s       (s),
    .a       (a),
    .d       (d),
    .wa      (wa),
    .wd      (wd),
    .as      (as),
    .ds      (ds),
    .stop    (stop),
    .tx_en   (tx_en),
    .uart_tx (uart_tx),
    .busy    (busy),
    .sent_cmd(sent_cmd),
    .err_dir (err_dir)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] flags);
    {w, s, a, d, wa, wd, as, ds, stop} = flags;
  endtask

  task automatic waitBusy(input logic level, input int budget, input string tag, output int at);
    int n;
    n = 0;
    while (busy !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, busy, level);
    at = cycle;
  endtask

  // Serial monitor: samples each bit near its centre and scores the frame against the expected queue.
  initial begin : monitor
    logic [7:0] rxByte;
    logic [7:0] expByte;
    forever begin
      @(negedge clk);
      if (monEnable && rst_n === 1'b1 && uart_tx === 1'b0) begin
        startQ.push_back(cycle);
        checkOutput("frame was expected", 32'(expQ.size() != 0), 32'd1);
        expByte = (expQ.size() != 0) ? expQ.pop_front() : 8'hxx;
        checkOutput("sent_cmd at frame start", sent_cmd, expByte);
        checkOutput("busy at frame start", busy, 1);
        repeat (4) @(negedge clk);
        checkOutput("start bit", uart_tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          rxByte[i] = uart_tx;
        end
`ifdef DIR_TX_PARITY_EN
        repeat (10) @(negedge clk);
        checkOutput("parity bit", uart_tx, ^rxByte);
`endif
        repeat (10) @(negedge clk);
        checkOutput("stop bit", uart_tx, 1);
        checkOutput("frame byte", rxByte, expByte);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] aborting");
  end

  initial begin : stimulus
    int riseAt, fallAt, nStarts;

    rst_n = 1'b0;
    tx_en = 1'b1;
    applyStimulus(9'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset uart_tx", uart_tx, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset sent_cmd", sent_cmd, 8'h00);
    checkOutput("reset err_dir", err_dir, 0);

    $display("[TB] case 1: single forward command");
    rst_n = 1'b1;
    applyStimulus(F_W);
    expQ.push_back(8'h01);
    @(negedge clk);
    checkOutput("t1 line idle after one edge", uart_tx, 1);
    @(negedge clk);
    checkOutput("t1 start bit after two edges", uart_tx, 0);
    checkOutput("t1 busy rises with start bit", busy, 1);
    riseAt = cycle;
    waitBusy(1'b0, FRAME_CLKS + 20, "t1 busy falls", fallAt);
    checkOutput("t1 busy length", fallAt - riseAt, FRAME_CLKS);
    checkOutput("t1 line idle at busy fall", uart_tx, 1);
    checkOutput("t1 sent_cmd", sent_cmd, 8'h01);

    $display("[TB] case 2: encoding sequence");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(SEQ_FLAGS[i]);
      expQ.push_back(SEQ_BYTES[i]);
      waitBusy(1'b1, 10, "t2 frame starts", riseAt);
      waitBusy(1'b0, FRAME_CLKS + 20, "t2 frame ends", fallAt);
    end

    $display("[TB] case 3: changes while in flight");
    applyStimulus(F_W);
    expQ.push_back(8'h01);
    waitBusy(1'b1, 10, "t3 first frame starts", riseAt);
    repeat (15) @(negedge clk);
    applyStimulus(F_S);
    repeat (20) @(negedge clk);
    applyStimulus(F_D);
    expQ.push_back(8'h08);
    waitBusy(1'b0, 2 * FRAME_CLKS + 20, "t3 busy falls", fallAt);
    checkOutput("t3 busy across two frames", fallAt - riseAt, 2 * FRAME_CLKS);
    checkOutput("t3 back-to-back start", startQ[$] - startQ[$-1], FRAME_CLKS);
    checkOutput("t3 all frames seen", expQ.size(), 0);
    checkOutput("t3 err_dir still clear", err_dir, 0);

    $display("[TB] case 4: illegal combination");
    applyStimulus(F_W | F_D);
    expQ.push_back(8'h00);
    @(negedge clk);
    checkOutput("t4 err_dir set", err_dir, 1);
    waitBusy(1'b1, 10, "t4 frame starts", riseAt);
    waitBusy(1'b0, FRAME_CLKS + 20, "t4 frame ends", fallAt);
    checkOutput("t4 err_dir held", err_dir, 1);
    applyStimulus(F_D);
    expQ.push_back(8'h08);
    waitBusy(1'b1, 10, "t4 legal frame starts", riseAt);
    waitBusy(1'b0, FRAME_CLKS + 20, "t4 legal frame ends", fallAt);
    checkOutput("t4 err_dir sticky", err_dir, 1);

    $display("[TB] case 5: periodic refresh and tx_en");
    expQ.push_back(8'h08);
    expQ.push_back(8'h08);
    for (int i = 0; i < 2; i++) begin
      waitBusy(1'b1, REFRESH_PERIOD + 20, "t5 refresh starts", riseAt);
      waitBusy(1'b0, FRAME_CLKS + 20, "t5 refresh ends", fallAt);
    end
    checkOutput("t5 refresh period 1", startQ[$-1] - startQ[$-2], REFRESH_PERIOD);
    checkOutput("t5 refresh period 2", startQ[$] - startQ[$-1], REFRESH_PERIOD);
    expQ.push_back(8'h08);
    waitBusy(1'b1, REFRESH_PERIOD + 20, "t5 third refresh starts", riseAt);
    repeat (30) @(negedge clk);
    tx_en = 1'b0;
    waitBusy(1'b0, FRAME_CLKS + 20, "t5 frame completes", fallAt);
    checkOutput("t5 frame length with tx_en low", fallAt - riseAt, FRAME_CLKS);
    nStarts = startQ.size();
    repeat (3 * REFRESH_PERIOD) @(negedge clk);
    checkOutput("t5 no frames while disabled", startQ.size(), nStarts);
    checkOutput("t5 idle while disabled", busy, 0);
    tx_en = 1'b1;
    expQ.push_back(8'h08);
    @(negedge clk);
    checkOutput("t5 held refresh sends at once", busy, 1);
    waitBusy(1'b0, FRAME_CLKS + 20, "t5 resumed frame ends", fallAt);

    $display("[TB] case 6: reset mid-frame");
    monEnable = 1'b0;
    applyStimulus(F_S);
    waitBusy(1'b1, 10, "t6 frame starts", riseAt);
    repeat (54) @(negedge clk);
    checkOutput("t6 data bit 4 low", uart_tx, 0);
    checkOutput("t6 busy before reset", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6 async uart_tx", uart_tx, 1);
    checkOutput("t6 async busy", busy, 0);
    checkOutput("t6 async sent_cmd", sent_cmd, 8'h00);
    checkOutput("t6 async err_dir", err_dir, 0);
    applyStimulus(F_STOP);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    checkOutput("t6 frame abandoned", busy, 0);
    checkOutput("t6 line idle after reset", uart_tx, 1);
    monEnable = 1'b1;
    checkOutput("no outstanding expected frames", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
